// File: rtl/game_input_ctrl.sv
// game_input_ctrl
// ----------------
// N-channel push-button front end. Each raw button input is polarity
// normalised and passed through a two-flop synchroniser. It is then debounced
// into a clean level. That level drives a small per-channel FSM that produces
// a press pulse, an auto-repeat pulse train while the button is held, and a
// release pulse. All logic is on the rising edge of clock with a synchronous
// active-low reset.
//
// Ports:
//   clock          in   system clock
//   resetn         in   synchronous active-low reset
//   btn_in         in   [NUM_CH] raw asynchronous button inputs
//   repeat_mask    in   [NUM_CH] per-channel auto-repeat enable
//   level          out  [NUM_CH] debounced pressed state (1 = pressed)
//   press_pulse    out  [NUM_CH] one cycle when a press is debounced
//   repeat_pulse   out  [NUM_CH] one cycle per auto-repeat
//   release_pulse  out  [NUM_CH] one cycle when a release is debounced
//   event_pulse    out  [NUM_CH] press_pulse | repeat_pulse
//
// Optional feature, macro INPUT_CTRL_LOCKOUT_EN:
//   Channels (2k, 2k+1) form opposing pairs. A press that is debounced while
//   the partner is held leaves that channel locked. A locked channel still
//   reports level and release, but it raises no press, repeat or event
//   pulses until it is released. When both channels of a pair rise together,
//   the even channel wins. NUM_CH must be even when the macro is defined.
//
// Handshake: there is none. Every output is a registered level or a
// single-cycle pulse that the consumer samples on each clock edge.

module game_input_ctrl #(
    parameter int NUM_CH           = 4,
    parameter int ACTIVE_LOW       = 1,
    parameter int CNT_W            = 20,
    parameter int DEBOUNCE_CYC     = 250000,
    parameter int REPEAT_DELAY_CYC = 20000000,
    parameter int REPEAT_RATE_CYC  = 5000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] repeat_mask,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] repeat_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] event_pulse
);

    // The counters are widened when CNT_W is too narrow for the largest cycle
    // parameter. A narrow counter would truncate its terminal count and give
    // silently wrong timing.
    localparam int MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
    localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
    localparam int NEED_W  = $clog2(MAX_CYC + 1);
    localparam int CW      = (CNT_W > NEED_W) ? CNT_W : NEED_W;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Polarity-normalised input: 1 means pressed, whatever the board wiring.
    logic [NUM_CH-1:0] pressed_raw;
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef INPUT_CTRL_LOCKOUT_EN
    logic [NUM_CH-1:0] rise_v;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CW-1:0] dcnt_q;
        logic [CW-1:0] rcnt_q;
        state_t        state_q;
        logic          level_q;
        logic          press_q;
        logic          repeat_q;
        logic          release_q;
        logic          event_q;
        logic          flip;
        logic          rise;
        logic          fall;
        logic          fire;
        logic          press_ok;
        logic          rep_ok;

        // The debounced level flips once the synchronised input has differed
        // from it for DEBOUNCE_CYC consecutive cycles.
        assign flip = (sync2_q[g] != level_q) && (dcnt_q == DEB_LAST);
        assign rise = flip & sync2_q[g];
        assign fall = flip & ~sync2_q[g];

        // A repeat fires on the terminal count of the current phase. A mask
        // that is low or a release in the same cycle suppresses it.
        assign fire = repeat_mask[g] & ~fall &
                      (((state_q == ST_DELAY)  && (rcnt_q == DLY_LAST)) ||
                       ((state_q == ST_REPEAT) && (rcnt_q == RATE_LAST)));

`ifdef INPUT_CTRL_LOCKOUT_EN
        localparam bit IS_HI = (g % 2) == 1;
        logic locked_q;
        logic lock_now;

        assign rise_v[g] = rise;
        // The partner already held, or the partner rising in the same cycle
        // when this is the odd channel of the pair.
        assign lock_now  = level[g ^ 1] | (rise_v[g ^ 1] & IS_HI);
        assign press_ok  = rise & ~lock_now;
        assign rep_ok    = fire & ~locked_q;

        always_ff @(posedge clock) begin
            if (!resetn) begin
                locked_q <= 1'b0;
            end else if (fall) begin
                locked_q <= 1'b0;
            end else if (rise) begin
                locked_q <= lock_now;
            end
        end
`else
        assign press_ok = rise;
        assign rep_ok   = fire;
`endif

        always_ff @(posedge clock) begin
            if (!resetn) begin
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                state_q   <= ST_IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                repeat_q  <= 1'b0;
                release_q <= 1'b0;
                event_q   <= 1'b0;
            end else begin
                if ((sync2_q[g] == level_q) || flip) begin
                    dcnt_q <= '0;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
                if (flip) begin
                    level_q <= sync2_q[g];
                end

                press_q   <= press_ok;
                repeat_q  <= rep_ok;
                release_q <= fall;
                event_q   <= press_ok | rep_ok;

                if (fall) begin
                    state_q <= ST_IDLE;
                    rcnt_q  <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rise) begin
                                state_q <= ST_DELAY;
                                rcnt_q  <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (!repeat_mask[g]) begin
                                rcnt_q <= '0;
                            end else if (rcnt_q == DLY_LAST) begin
                                state_q <= ST_REPEAT;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (!repeat_mask[g]) begin
                                state_q <= ST_DELAY;
                                rcnt_q  <= '0;
                            end else if (rcnt_q == RATE_LAST) begin
                                rcnt_q <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end

        assign level[g]         = level_q;
        assign press_pulse[g]   = press_q;
        assign repeat_pulse[g]  = repeat_q;
        assign release_pulse[g] = release_q;
        assign event_pulse[g]   = event_q;
    end

endmodule
